// File: rtl/dm_pkg.sv
// Shared types for the data-memory copy arbiter: copy FSM states and memory sizing.
package dm_pkg;
  localparam int DM_ADDRESS_DEF = 9;
  localparam int DM_WORDS       = 2**DM_ADDRESS_DEF;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} cp_state_t;
endpackage

// File: rtl/dm_copy_seq.sv
// Block-copy sequencer: one word at a time through a single buffer register,
// walking offsets downward when the destination overlaps the source tail.
module dm_copy_seq
  import dm_pkg::*;
#(
  parameter int DM_ADDRESS = DM_ADDRESS_DEF,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           src_in,
  input  logic [31:0]           dst_in,
  input  logic [31:0]           len_in,
  input  logic                  grant,
  input  logic [DATA_W-1:0]     mem_rd,
  output logic [DM_ADDRESS-1:0] addr,
  output logic                  re,
  output logic                  we,
  output logic [DATA_W-1:0]     wd,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int AW1 = DM_ADDRESS + 1;
  localparam logic [31:0] WORDS = 32'(2**DM_ADDRESS);

  cp_state_t state, nstate;
  logic [DM_ADDRESS-1:0] src_q, dst_q, off_q;
  logic [AW1-1:0]        rem_q;
  logic                  desc_q, err_q;
  logic [DATA_W-1:0]     buf_q;

  logic [AW1-1:0] len_c, src_w, dst_w, end_w, lm1;
  logic           desc_c;
  logic           unused_hi;

  assign unused_hi = ^{src_in[31:DM_ADDRESS], dst_in[31:DM_ADDRESS]};

  // Overlap test is done unwrapped so a copy across the top of memory runs ascending.
  assign len_c  = (len_in > WORDS) ? WORDS[AW1-1:0] : len_in[AW1-1:0];
  assign src_w  = {1'b0, src_in[DM_ADDRESS-1:0]};
  assign dst_w  = {1'b0, dst_in[DM_ADDRESS-1:0]};
  assign end_w  = src_w + len_c;
  assign desc_c = (src_w < dst_w) && (dst_w < end_w);
  assign lm1    = len_c - 1'b1;

  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (start) nstate = (len_c == '0) ? DONE : RD;
      RD:   if (grant) nstate = WR;
      WR:   if (grant) nstate = (rem_q == AW1'(1)) ? DONE : RD;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      off_q  <= '0;
      rem_q  <= '0;
      desc_q <= 1'b0;
      buf_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= nstate;
      err_q <= start && (state != IDLE);
      case (state)
        IDLE: if (start) begin
          src_q  <= src_in[DM_ADDRESS-1:0];
          dst_q  <= dst_in[DM_ADDRESS-1:0];
          rem_q  <= len_c;
          desc_q <= desc_c;
          off_q  <= desc_c ? lm1[DM_ADDRESS-1:0] : '0;
        end
        RD: if (grant) buf_q <= mem_rd;
        WR: if (grant) begin
          rem_q <= rem_q - 1'b1;
          off_q <= desc_q ? off_q - 1'b1 : off_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign addr = (state == WR) ? dst_q + off_q : src_q + off_q;
  assign re   = (state == RD);
  assign we   = (state == WR);
  assign wd   = buf_q;
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = err_q;
endmodule

// File: rtl/dm_copy_arbiter.sv
// Single-port data memory arbiter: CPU load/store has priority, the copy engine
// is forced through after STARVE_MAX consecutive denials.
module dm_copy_arbiter
  import dm_pkg::*;
#(
  parameter int DM_ADDRESS = DM_ADDRESS_DEF,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wd,
  output logic [DATA_W-1:0]     cpu_rd,
  output logic                  cpu_stall,
  input  logic                  cp_start,
  input  logic [31:0]           cp_src,
  input  logic [31:0]           cp_dst,
  input  logic [31:0]           cp_len,
  output logic                  cp_busy,
  output logic                  cp_done,
  output logic                  cp_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rd
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]         starve_cnt;
  logic                  cpu_req, cpu_gnt, cp_act, cp_gnt;
  logic [DM_ADDRESS-1:0] seq_addr;
  logic                  seq_re, seq_we;
  logic [DATA_W-1:0]     seq_wd;

  dm_copy_seq #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (cp_start),
    .src_in (cp_src),
    .dst_in (cp_dst),
    .len_in (cp_len),
    .grant  (cp_gnt),
    .mem_rd (mem_rd),
    .addr   (seq_addr),
    .re     (seq_re),
    .we     (seq_we),
    .wd     (seq_wd),
    .busy   (cp_busy),
    .done   (cp_done),
    .err    (cp_err)
  );

  assign cpu_req   = cpu_re | cpu_we;
  assign cp_act    = seq_re | seq_we;
  assign cpu_gnt   = cpu_req && (starve_cnt < SW'(STARVE_MAX));
  assign cp_gnt    = cp_act && !cpu_gnt;
  assign cpu_stall = cpu_req && !cpu_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                starve_cnt <= '0;
    else if (!cp_act || cp_gnt) starve_cnt <= '0;
    else                       starve_cnt <= starve_cnt + 1'b1;
  end

  // Write wins when the CPU asserts both strobes, so no read data is returned.
  always_comb begin
    mem_addr = '0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    cpu_rd   = '0;
    if (cpu_gnt) begin
      mem_addr = cpu_addr;
      mem_we   = cpu_we;
      mem_re   = cpu_re & ~cpu_we;
      mem_wd   = cpu_wd;
      cpu_rd   = (cpu_re & ~cpu_we) ? mem_rd : '0;
    end else if (cp_gnt) begin
      mem_addr = seq_addr;
      mem_re   = seq_re;
      mem_we   = seq_we;
      mem_wd   = seq_wd;
    end
  end
endmodule

// File: tb/tb_dm_copy_arbiter.sv
// Directed bench for dm_copy_arbiter against a behavioural word memory.
module tb_dm_copy_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [8:0]  cpu_addr = '0;
  logic [31:0] cpu_wd = '0, cpu_rd;
  logic        cpu_stall;
  logic        cp_start = 1'b0;
  logic [31:0] cp_src = '0, cp_dst = '0, cp_len = '0;
  logic        cp_busy, cp_done, cp_err;
  logic [8:0]  mem_addr;
  logic        mem_re, mem_we;
  logic [31:0] mem_wd, mem_rd;
  logic [31:0] mem [512];

  int checks = 0, passed = 0, fails = 0;

  dm_copy_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .cp_start(cp_start), .cp_src(cp_src), .cp_dst(cp_dst), .cp_len(cp_len),
    .cp_busy(cp_busy), .cp_done(cp_done), .cp_err(cp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory model: word i starts as 0x5A00_0000 | i.
  assign mem_rd = mem[mem_addr];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] <= mem_wd;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue cp_start in the current cycle (cycle 0); returns in cycle 1.
  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    cp_src = s; cp_dst = d; cp_len = l; cp_start = 1'b1;
    step();
    cp_start = 1'b0;
  endtask

  initial begin
    int done_cyc, busy_n, we_n, done_n, k;
    logic [31:0] smask, emask, bmask;
    logic [8:0]  ra [4];

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", cp_busy, 0);
    chk("rst_done", cp_done, 0);
    chk("rst_err", cp_err, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_cpu_rd", cpu_rd, 0);
    rst_n = 1'b1;
    step();

    // Disjoint copy 0x10 -> 0x40, len 4
    start_copy(32'h10, 32'h40, 4);
    done_cyc = -1; busy_n = 0; we_n = 0;
    for (int c = 1; c <= 12; c++) begin
      if (cp_busy) busy_n++;
      if (mem_we) we_n++;
      if (cp_done && done_cyc < 0) done_cyc = c;
      step();
    end
    chk("disj_done_cycle", done_cyc, 9);
    chk("disj_busy_cycles", busy_n, 9);
    chk("disj_writes", we_n, 4);
    for (int i = 0; i < 4; i++) chk("disj_data", mem[9'h40 + 9'(i)], 32'h5A00_0010 + 32'(i));

    // Overlapping forward move 0x20 -> 0x22, len 4: must walk downward
    start_copy(32'h20, 32'h22, 4);
    for (int c = 1; c <= 12; c++) begin
      if (c <= 4) ra[c-1] = mem_addr;
      step();
    end
    chk("ovl_addr0", ra[0], 9'h23);
    chk("ovl_addr1", ra[1], 9'h25);
    chk("ovl_addr2", ra[2], 9'h22);
    chk("ovl_addr3", ra[3], 9'h24);
    for (int i = 0; i < 4; i++) chk("ovl_data", mem[9'h22 + 9'(i)], 32'h5A00_0020 + 32'(i));

    // CPU reads every cycle during a len=2 copy
    cpu_re = 1'b1; cpu_addr = 9'h10;
    start_copy(32'h60, 32'h70, 2);
    smask = '0; done_cyc = -1;
    for (int c = 1; c <= 24; c++) begin
      if (cpu_stall) smask[c] = 1'b1;
      if (cp_done && done_cyc < 0) done_cyc = c;
      if (c == 1) chk("cont_cpu_rd_granted", cpu_rd, 32'h5A00_0010);
      if (c == 5) chk("cont_cpu_rd_stalled", cpu_rd, 0);
      step();
    end
    cpu_re = 1'b0;
    chk("cont_stall_mask", smask, 32'h0010_8420);
    chk("cont_done_cycle", done_cyc, 21);
    chk("cont_data0", mem[9'h70], 32'h5A00_0060);
    chk("cont_data1", mem[9'h71], 32'h5A00_0061);

    // Zero-length copy
    start_copy(32'h10, 32'h30, 0);
    done_cyc = -1; busy_n = 0; we_n = 0;
    for (int c = 1; c <= 3; c++) begin
      if (cp_busy) busy_n++;
      if (mem_we) we_n++;
      if (cp_done && done_cyc < 0) done_cyc = c;
      step();
    end
    chk("len0_done_cycle", done_cyc, 1);
    chk("len0_writes", we_n, 0);
    chk("len0_busy_cycles", busy_n, 1);

    // Source wraps past top of memory; ascending, so later reads see fresh writes
    start_copy(32'h1FE, 32'h0, 4);
    k = 0; done_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      if (mem_re && k < 4) begin ra[k] = mem_addr; k++; end
      if (cp_done && done_cyc < 0) done_cyc = c;
      step();
    end
    chk("wrap_rd0", ra[0], 9'h1FE);
    chk("wrap_rd1", ra[1], 9'h1FF);
    chk("wrap_rd2", ra[2], 9'h000);
    chk("wrap_rd3", ra[3], 9'h001);
    chk("wrap_done_cycle", done_cyc, 9);
    chk("wrap_data0", mem[0], 32'h5A00_01FE);
    chk("wrap_data2", mem[2], 32'h5A00_01FE);
    chk("wrap_data3", mem[3], 32'h5A00_01FF);

    // Start while busy (cycle 2) and in DONE (cycle 7): both dropped with cp_err
    start_copy(32'h100, 32'h140, 3);
    emask = '0; bmask = '0; done_n = 0; done_cyc = -1;
    cp_src = 32'h1B0; cp_dst = 32'h1A0; cp_len = 1;
    for (int c = 1; c <= 12; c++) begin
      if (cp_err) emask[c] = 1'b1;
      if (cp_busy) bmask[c] = 1'b1;
      if (cp_done) begin done_n++; if (done_cyc < 0) done_cyc = c; end
      cp_start = (c == 2 || c == 7);
      step();
    end
    cp_start = 1'b0;
    chk("err_mask", emask, 32'h0000_0108);
    chk("err_busy_mask", bmask, 32'h0000_00FE);
    chk("err_done_count", done_n, 1);
    chk("err_done_cycle", done_cyc, 7);
    for (int i = 0; i < 3; i++) chk("err_data", mem[9'h140 + 9'(i)], 32'h5A00_0100 + 32'(i));
    chk("err_dropped_copy", mem[9'h1A0], 32'h5A00_01A0);

    // Reset at cycle 3 of a len=8 copy
    start_copy(32'h80, 32'hC0, 8);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", cp_busy, 0);
    chk("rstmid_mem_we", mem_we, 0);
    chk("rstmid_mem_re", mem_re, 0);
    chk("rstmid_done", cp_done, 0);
    step();
    chk("rstmid_partial0", mem[9'hC0], 32'h5A00_0080);
    chk("rstmid_partial1", mem[9'hC1], 32'h5A00_00C1);
    rst_n = 1'b1;
    step();
    start_copy(32'h90, 32'hD0, 2);
    done_cyc = -1;
    for (int c = 1; c <= 8; c++) begin
      if (cp_done && done_cyc < 0) done_cyc = c;
      step();
    end
    chk("rstmid_new_done_cycle", done_cyc, 5);
    chk("rstmid_new_data0", mem[9'hD0], 32'h5A00_0090);
    chk("rstmid_new_data1", mem[9'hD1], 32'h5A00_0091);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
